// File: rtl/tiny_riscv_mem_pkg.sv
// rtl/tiny_riscv_mem_pkg.sv - shared widths and pipeline stage metadata for the tiny RISC-V BRAM
package tiny_riscv_mem_pkg;

    localparam int XLEN    = 32;
    localparam int WMASK_W = 4;
    localparam int BYTE_W  = XLEN / WMASK_W;

    // Sideband carried alongside each request while its array read is in flight.
    typedef struct packed {
        logic valid;
        logic err;
        logic rd;
    } stage_meta_t;

endpackage

// File: rtl/tiny_riscv_bram_array.sv
// rtl/tiny_riscv_bram_array.sv - single-port byte-writable word store with registered read port
module tiny_riscv_bram_array
    import tiny_riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1536,
    parameter int ADDR_W      = 11,
    parameter     INIT_FILE   = ""
) (
    input  logic               clk_i,
    input  logic               en_i,
    input  logic [WMASK_W-1:0] we_i,
    input  logic [ADDR_W-1:0]  addr_i,
    input  logic [XLEN-1:0]    wdata_i,
    output logic [XLEN-1:0]    rdata_o
);

    logic [XLEN-1:0] mem_q [DEPTH_WORDS];
    logic [XLEN-1:0] rdata_q;

    // Output register only loads on an enabled read, so it holds through stalls.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int b = 0; b < WMASK_W; b++) begin
                if (we_i[b]) begin
                    mem_q[addr_i][b*BYTE_W +: BYTE_W] <= wdata_i[b*BYTE_W +: BYTE_W];
                end
            end
            if (we_i == '0) begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tiny_riscv_bram.sv
// rtl/tiny_riscv_bram.sv - valid/ready memory port with range check and 1- or 2-cycle read latency
module tiny_riscv_bram
    import tiny_riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS  = 1536,
    parameter int READ_LATENCY = 1,
    parameter     INIT_FILE    = ""
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic [XLEN-1:0]    i_req_addr,
    input  logic [WMASK_W-1:0] i_req_wmask,
    input  logic [XLEN-1:0]    i_req_wdata,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [XLEN-1:0]    o_rsp_rdata,
    output logic               o_rsp_err
);

    localparam int ADDR_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [XLEN-3:0] DEPTH_IDX = (XLEN-2)'(DEPTH_WORDS);

    logic               advance;
    logic               accept;
    logic               req_oor;
    logic               req_wr;
    logic               arr_en;
    logic [WMASK_W-1:0] arr_we;
    logic [XLEN-1:0]    arr_rdata;
    logic [XLEN-1:0]    s1_rdata;
    logic [1:0]         unused_addr_lsb;
    stage_meta_t        s1_q;
    stage_meta_t        s1_d;

    assign unused_addr_lsb = i_req_addr[1:0];

    assign advance     = ~o_rsp_valid | i_rsp_ready;
    assign o_req_ready = advance;
    assign accept      = i_req_valid & advance;
    assign req_oor     = (i_req_addr[XLEN-1:2] >= DEPTH_IDX);
    assign req_wr      = (i_req_wmask != '0);

    // Gating with reset keeps a request presented on the reset edge away from the array.
    assign arr_en = accept & ~req_oor & i_Rst_n;
    assign arr_we = arr_en ? i_req_wmask : '0;

    tiny_riscv_bram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W),
        .INIT_FILE   (INIT_FILE)
    ) u_array (
        .clk_i   (i_Clk),
        .en_i    (arr_en),
        .we_i    (arr_we),
        .addr_i  (i_req_addr[ADDR_W+1:2]),
        .wdata_i (i_req_wdata),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        s1_d = s1_q;
        if (advance) begin
            s1_d.valid = accept;
            s1_d.err   = accept & req_oor;
            s1_d.rd    = accept & ~req_oor & ~req_wr;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            s1_q <= '0;
        end else begin
            s1_q <= s1_d;
        end
    end

    assign s1_rdata = (s1_q.valid & s1_q.rd) ? arr_rdata : '0;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic            s2_valid_q, s2_valid_d;
            logic            s2_err_q, s2_err_d;
            logic [XLEN-1:0] s2_rdata_q, s2_rdata_d;

            always_comb begin
                s2_valid_d = s2_valid_q;
                s2_err_d   = s2_err_q;
                s2_rdata_d = s2_rdata_q;
                if (advance) begin
                    s2_valid_d = s1_q.valid;
                    s2_err_d   = s1_q.valid & s1_q.err;
                    s2_rdata_d = s1_rdata;
                end
            end

            always_ff @(posedge i_Clk) begin
                if (!i_Rst_n) begin
                    s2_valid_q <= 1'b0;
                    s2_err_q   <= 1'b0;
                    s2_rdata_q <= '0;
                end else begin
                    s2_valid_q <= s2_valid_d;
                    s2_err_q   <= s2_err_d;
                    s2_rdata_q <= s2_rdata_d;
                end
            end

            assign o_rsp_valid = s2_valid_q;
            assign o_rsp_err   = s2_err_q;
            assign o_rsp_rdata = s2_rdata_q;
        end else begin : g_lat1
            assign o_rsp_valid = s1_q.valid;
            assign o_rsp_err   = s1_q.valid & s1_q.err;
            assign o_rsp_rdata = s1_rdata;
        end
    endgenerate

endmodule

// File: tb/tb_tiny_riscv_bram.sv
// tb/tb_tiny_riscv_bram.sv - directed bench for tiny_riscv_bram at read latencies 1 and 2
module tb_tiny_riscv_bram;

    localparam int DEPTH = 1536;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_addr  [2];
    logic [3:0]  req_wmask [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    always #5 clk = ~clk;

    tiny_riscv_bram #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(1)) u_dut_l1 (
        .i_Clk(clk), .i_Rst_n(rst_n),
        .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]), .i_req_addr(req_addr[0]),
        .i_req_wmask(req_wmask[0]), .i_req_wdata(req_wdata[0]),
        .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
        .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0])
    );

    tiny_riscv_bram #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(2)) u_dut_l2 (
        .i_Clk(clk), .i_Rst_n(rst_n),
        .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]), .i_req_addr(req_addr[1]),
        .i_req_wmask(req_wmask[1]), .i_req_wdata(req_wdata[1]),
        .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
        .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1])
    );

    // Model: byte-addressed memory plus an in-order list of pending responses, each
    // tagged with the advancing-edge count at acceptance; a response is due once it
    // has seen exactly READ_LATENCY advancing edges.
    logic [31:0] mem_m   [2][DEPTH];
    logic [3:0]  known_m [2][DEPTH];
    int          q_tick  [2][16];
    logic [31:0] q_data  [2][16];
    logic        q_err   [2][16];
    logic        q_chk   [2][16];
    int          q_head  [2];
    int          q_cnt   [2];
    int          tick    [2];
    logic        rst_q = 1'b1;
    int          cyc = 0;

    logic [31:0] log_data [2][128];
    logic        log_err  [2][128];
    int          log_cyc  [2][128];
    int          logn     [2];

    int n_vec  = 0;
    int n_fail = 0;

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic logic model_valid(input int d);
        return (q_cnt[d] > 0) && ((tick[d] - q_tick[d][q_head[d]]) == lat(d));
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[L%0d] t=%0t: got %h, required %h", nm, lat(d), $time, act, exp);
        end
    endtask

    initial begin
        logic ev, adv;
        int   idx, wi;
        forever begin
            @(posedge clk);
            cyc++;
            rst_q = !rst_n;
            for (int d = 0; d < 2; d++) begin
                ev  = model_valid(d);
                adv = !ev || rsp_ready[d];
                if (!rst_n) begin
                    q_cnt[d]  = 0;
                    q_head[d] = 0;
                end else if (adv) begin
                    if (ev) begin
                        q_head[d] = (q_head[d] + 1) % 16;
                        q_cnt[d]--;
                    end
                    tick[d]++;
                    if (req_valid[d]) begin
                        wi  = int'(req_addr[d][31:2]);
                        idx = (q_head[d] + q_cnt[d]) % 16;
                        q_tick[d][idx] = tick[d] - 1;
                        if (wi >= DEPTH) begin
                            q_err[d][idx] = 1'b1; q_data[d][idx] = 32'h0; q_chk[d][idx] = 1'b1;
                        end else if (req_wmask[d] == 4'h0) begin
                            q_err[d][idx]  = 1'b0;
                            q_data[d][idx] = mem_m[d][wi];
                            q_chk[d][idx]  = (known_m[d][wi] == 4'hF);
                        end else begin
                            for (int b = 0; b < 4; b++)
                                if (req_wmask[d][b]) mem_m[d][wi][8*b +: 8] = req_wdata[d][8*b +: 8];
                            known_m[d][wi] = known_m[d][wi] | req_wmask[d];
                            q_err[d][idx] = 1'b0; q_data[d][idx] = 32'h0; q_chk[d][idx] = 1'b1;
                        end
                        q_cnt[d]++;
                    end
                end
            end
        end
    end

    initial begin
        logic ev;
        int   h;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst_q) begin
                    chk("rst_valid", d, {31'b0, rsp_valid[d]}, 32'h0);
                    chk("rst_rdata", d, rsp_rdata[d], 32'h0);
                    chk("rst_err",   d, {31'b0, rsp_err[d]}, 32'h0);
                end else begin
                    ev = model_valid(d);
                    chk("rsp_valid", d, {31'b0, rsp_valid[d]}, {31'b0, ev});
                    chk("req_ready", d, {31'b0, req_ready[d]}, {31'b0, (!ev || rsp_ready[d])});
                    if (ev) begin
                        h = q_head[d];
                        chk("rsp_err", d, {31'b0, rsp_err[d]}, {31'b0, q_err[d][h]});
                        if (q_chk[d][h]) chk("rsp_rdata", d, rsp_rdata[d], q_data[d][h]);
                        if (rsp_ready[d] && logn[d] < 128) begin
                            log_data[d][logn[d]] = rsp_rdata[d];
                            log_err[d][logn[d]]  = rsp_err[d];
                            log_cyc[d][logn[d]]  = cyc;
                            logn[d]++;
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input int d, input logic [31:0] a, input logic [3:0] m, input logic [31:0] w);
        logic acc;
        logic done;
        req_valid[d] = 1'b1; req_addr[d] = a; req_wmask[d] = m; req_wdata[d] = w;
        done = 1'b0;
        for (int t = 0; t < 64 && !done; t++) begin
            @(negedge clk);
            acc = req_ready[d];
            step();
            done = acc;
        end
        if (!done) begin
            n_vec++; n_fail++;
            $display("FAIL issue_timeout[L%0d]: req_ready stayed 0 for addr %h, required 1", lat(d), a);
        end
    endtask

    task automatic idle(input int d, input int n);
        req_valid[d] = 1'b0;
        repeat (n) step();
    endtask

    task automatic check_log(input int d, input int i, input logic [31:0] exp_d, input logic exp_e, input string nm);
        if (i >= logn[d]) begin
            n_vec++; n_fail++;
            $display("FAIL %s[L%0d]: response %0d missing (got %0d responses), required present", nm, lat(d), i, logn[d]);
        end else begin
            chk({nm, "_data"}, d, log_data[d][i], exp_d);
            chk({nm, "_err"},  d, {31'b0, log_err[d][i]}, {31'b0, exp_e});
        end
    endtask

    task automatic run_dut(input int d);
        int          b;
        int          acc_cyc;
        logic [15:0] pat;
        b = logn[d];
        issue(d, 32'h400, 4'hF, 32'h04030201);
        issue(d, 32'h400, 4'h0, 32'h0);
        issue(d, 32'h404, 4'hF, 32'h08070605);
        issue(d, 32'h404, 4'h1, 32'h000000AA);
        issue(d, 32'h404, 4'h0, 32'h0);
        issue(d, 32'h000, 4'hF, 32'h11223344);
        issue(d, 32'h1800, 4'h0, 32'h0);
        issue(d, 32'h1800, 4'hF, 32'hDEADBEEF);
        issue(d, 32'h2000, 4'hF, 32'hCAFEF00D);
        issue(d, 32'h000, 4'h0, 32'h0);
        issue(d, 32'h408, 4'hF, 32'hA5A5A5A5);
        idle(d, 5);
        check_log(d, b + 0, 32'h0,        1'b0, "wr_rsp");
        check_log(d, b + 1, 32'h04030201, 1'b0, "rd_after_wr");
        check_log(d, b + 4, 32'h080706AA, 1'b0, "rd_bytemask");
        check_log(d, b + 6, 32'h0,        1'b1, "rd_oor");
        check_log(d, b + 7, 32'h0,        1'b1, "wr_oor");
        check_log(d, b + 8, 32'h0,        1'b1, "wr_oor_alias");
        check_log(d, b + 9, 32'h11223344, 1'b0, "idx0_kept");

        // Three back-to-back reads against a consumer that stalls for three cycles.
        b = logn[d];
        rsp_ready[d] = 1'b0;
        fork
            begin
                issue(d, 32'h400, 4'h0, 32'h0);
                issue(d, 32'h404, 4'h0, 32'h0);
                issue(d, 32'h408, 4'h0, 32'h0);
            end
            begin
                for (int i = 1; i <= 4; i++) begin
                    @(negedge clk);
                    if (d == 0 && i >= 2) begin
                        chk("stall_ready", d, {31'b0, req_ready[d]}, 32'h0);
                        chk("stall_hold",  d, rsp_rdata[d], 32'h04030201);
                    end
                    step();
                end
                rsp_ready[d] = 1'b1;
            end
        join
        idle(d, 5);
        check_log(d, b + 0, 32'h04030201, 1'b0, "stall_rsp0");
        check_log(d, b + 1, 32'h080706AA, 1'b0, "stall_rsp1");
        check_log(d, b + 2, 32'hA5A5A5A5, 1'b0, "stall_rsp2");

        for (int k = 3; k < 8; k++) issue(d, 32'h400 + 32'(4 * k), 4'hF, 32'h10000000 + 32'(k));
        idle(d, 4);
        b = logn[d];
        acc_cyc = 0;
        for (int k = 0; k < 8; k++) begin
            issue(d, 32'h400 + 32'(4 * k), 4'h0, 32'h0);
            if (k == 0) acc_cyc = cyc;
        end
        idle(d, 5);
        check_log(d, b + 0, 32'h04030201, 1'b0, "stream_first");
        check_log(d, b + 7, 32'h10000007, 1'b0, "stream_last");
        if (logn[d] >= b + 8) begin
            chk("stream_latency", d, 32'(log_cyc[d][b] - acc_cyc), 32'(lat(d) - 1));
            for (int i = 0; i < 7; i++)
                chk("stream_rate", d, 32'(log_cyc[d][b+i+1] - log_cyc[d][b+i]), 32'd1);
        end

        pat = 16'b1011_0010_1110_0101;
        fork
            begin
                for (int k = 0; k < 12; k++) begin
                    if (k % 3 == 0)
                        issue(d, 32'h420 + 32'(4 * (k % 8)), 4'((k % 15) + 1), 32'h01010101 * 32'(k + 1));
                    else
                        issue(d, 32'h420 + 32'(4 * (k % 8)), 4'h0, 32'h0);
                end
            end
            begin
                for (int i = 0; i < 16; i++) begin
                    rsp_ready[d] = pat[i];
                    step();
                end
                rsp_ready[d] = 1'b1;
            end
        join
        idle(d, 6);
    endtask

    task automatic reset_test(input int d);
        int b;
        rsp_ready[d] = 1'b1;
        issue(d, 32'h400, 4'h0, 32'h0);
        issue(d, 32'h404, 4'h0, 32'h0);
        rst_n = 1'b0;
        req_valid[d] = 1'b1; req_addr[d] = 32'h400; req_wmask[d] = 4'hF; req_wdata[d] = 32'hFFFFFFFF;
        step();
        @(negedge clk);
        chk("rst_flush", d, {31'b0, rsp_valid[d]}, 32'h0);
        step();
        rst_n = 1'b1;
        req_valid[d] = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", d, {31'b0, req_ready[d]}, 32'h1);
        step();
        b = logn[d];
        issue(d, 32'h400, 4'h0, 32'h0);
        idle(d, 5);
        check_log(d, b, 32'h04030201, 1'b0, "mem_kept_rst");
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_addr[d] = 32'h0; req_wmask[d] = 4'h0; req_wdata[d] = 32'h0;
            rsp_ready[d] = 1'b1;
            q_head[d] = 0; q_cnt[d] = 0; tick[d] = 0; logn[d] = 0;
            for (int i = 0; i < DEPTH; i++) begin
                known_m[d][i] = 4'h0;
                mem_m[d][i]   = 32'h0;
            end
        end
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("ready_first", d, {31'b0, req_ready[d]}, 32'h1);
        step();
        for (int d = 0; d < 2; d++) begin
            run_dut(d);
            reset_test(d);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time %0t exceeded, required completion", $time);
        $fatal(1, "timeout");
    end

endmodule
